// File: rtl/ifu_fetch.sv
// ifu_fetch - instruction-fetch front end.
//   Owns the fetch PC and issues sequential word fetches over a req/gnt +
//   in-order rvalid interface. Returned words are buffered in a small FIFO
//   and handed to decode as {instr, pc} through valid/ready. A redirect
//   reloads the PC, flushes the buffer and marks every in-flight response
//   for discard.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   npc_in     in   redirect target (low two bits ignored)
//   redirect   in   load npc_in as the new fetch PC, flush
//   im_req     out  fetch request valid
//   im_addr    out  word-aligned fetch address
//   im_gnt     in   request accepted when im_req & im_gnt
//   im_rvalid  in   response valid (in order, >=1 cycle after grant)
//   im_rdata   in   response instruction word
//   if_valid   out  buffered instruction available
//   if_instr   out  instruction at buffer head
//   if_pc      out  PC of instruction at buffer head
//   if_ready   in   decode accepts head when if_valid & if_ready
module ifu_fetch #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        redirect,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] inflight_q, inflight_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [31:0]   pc_q    [FIFO_DEPTH];

  logic          grant;
  logic          push;
  logic          pop;
  logic [SW-1:0] fifo_credit;
  logic [SW-1:0] outstanding;
  logic [31:0]   redirect_pc;
  logic          unused_npc_lo;

  assign redirect_pc   = {npc_in[31:2], 2'b00};
  assign unused_npc_lo = ^npc_in[1:0];

  // Buffer slots already claimed by held words plus kept in-flight requests;
  // issuing only while this is below depth means a kept response always
  // finds a free slot.
  assign fifo_credit = SW'(cnt_q) + SW'(inflight_q);
  assign outstanding = SW'(inflight_q) + SW'(discard_q);

  assign im_req  = !reset && !redirect
                   && (fifo_credit < SW'(FIFO_DEPTH))
                   && (outstanding < SW'(MAX_OUTST));
  assign im_addr = fetch_pc_q;

  assign if_valid = (cnt_q != '0);
  assign if_instr = instr_q[rptr_q];
  assign if_pc    = pc_q[rptr_q];

  assign grant = im_req && im_gnt;
  // Responses to pre-redirect requests are consumed first (in order).
  assign push  = im_rvalid && (discard_q == '0) && !redirect;
  assign pop   = if_valid && if_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (redirect) begin
      // Everything still outstanding becomes discard; a response arriving
      // in this very cycle is one of them and is retired immediately.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      discard_d  = discard_q + inflight_q - OW'(im_rvalid);
      inflight_d = '0;
      cnt_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (im_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - OW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wptr_d    = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      inflight_d = inflight_q + OW'(grant) - OW'(push);
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= PC_RESET;
      resp_pc_q  <= PC_RESET;
      inflight_q <= '0;
      discard_q  <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= PC_RESET;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      if (push) begin
        instr_q[wptr_q] <= im_rdata;
        pc_q[wptr_q]    <= resp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios followed by a randomized phase,
// all checked against a queue-based reference of the fetch/decode stream.
module tb_ifu_fetch;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_in;
  logic        redirect;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  ifu_fetch #(
    .PC_RESET  (PC_RESET),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .npc_in   (npc_in),
    .redirect (redirect),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_gnt   (im_gnt),
    .im_rvalid(im_rvalid),
    .im_rdata (im_rdata),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_ready (if_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } pend_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference state: requests granted but not answered, words decode should
  // see next, and the address the next grant must carry.
  pend_t       pend[$];
  ent_t        fq[$];
  logic [31:0] exp_fetch;
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];

  int unsigned gnt_pct;
  int unsigned rv_pct;
  bit          rst_prev;
  bit          hold_prev;
  logic [31:0] hold_addr;

  logic        s_req, s_valid, s_rv;
  logic [31:0] s_addr, s_pc, s_instr;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory side, sample at the falling edge,
  // compare against the reference, then advance the reference.
  task automatic tick();
    pend_t       p;
    bit          kept;
    bit          rv;
    bit          pop;
    bit          exp_req;
    int unsigned nonstale;
    im_gnt    = ($urandom_range(99) < gnt_pct);
    rv        = !reset && (pend.size() > 0) && ($urandom_range(99) < rv_pct);
    im_rvalid = rv;
    im_rdata  = rv ? memfn(pend[0].addr) : $urandom();
    @(negedge clk);
    s_req   = im_req;
    s_addr  = im_addr;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    s_rv    = rv;
    if (reset) begin
      chk("rst_req", im_req, 1'b0);
      if (rst_prev) begin
        chk("rst_addr", im_addr, PC_RESET);
        chk("rst_valid", if_valid, 1'b0);
        chk("rst_pc", if_pc, PC_RESET);
        chk("rst_instr", if_instr, 32'h0);
      end
      pend.delete();
      fq.delete();
      exp_fetch = PC_RESET;
      rst_prev  = 1'b1;
      hold_prev = 1'b0;
    end else begin
      rst_prev = 1'b0;
      nonstale = 0;
      foreach (pend[i]) if (!pend[i].stale) nonstale++;
      exp_req = !redirect && (fq.size() + nonstale < FIFO_DEPTH) && (pend.size() < MAX_OUTST);
      chk("req", im_req, exp_req);
      if (im_req) chk("addr", im_addr, exp_fetch);
      if (hold_prev && !redirect) begin
        chk("hold_req", im_req, 1'b1);
        chk("hold_addr", im_addr, hold_addr);
      end
      chk("valid", if_valid, fq.size() != 0);
      if (fq.size() != 0) begin
        chk("head_pc", if_pc, fq[0].pc);
        chk("head_instr", if_instr, fq[0].instr);
      end
      pop = (fq.size() != 0) && if_ready;
      if (pop) begin
        popped_pc.push_back(fq[0].pc);
        popped_instr.push_back(fq[0].instr);
      end
      kept = 1'b0;
      if (rv) begin
        p    = pend.pop_front();
        kept = !p.stale && !redirect;
      end
      hold_prev = im_req && !im_gnt;
      hold_addr = im_addr;
      if (redirect) begin
        fq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        exp_fetch = {npc_in[31:2], 2'b00};
      end else begin
        if (pop) fq.delete(0);
        if (kept) fq.push_back(ent_t'{p.addr, memfn(p.addr)});
        if (im_req && im_gnt) begin
          pend.push_back(pend_t'{im_addr, 1'b0});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    redirect  = 1'b0;
    npc_in    = '0;
    if_ready  = 1'b1;
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    im_rdata  = '0;
    gnt_pct   = 100;
    rv_pct    = 100;
    rst_prev  = 1'b0;
    hold_prev = 1'b0;
    hold_addr = '0;
    exp_fetch = PC_RESET;

    // Streaming with grant and one-cycle responses always available.
    do_reset();
    popped_pc.delete();
    tick();
    chk("t1_first_req", s_req, 1'b1);
    chk("t1_first_addr", s_addr, 32'h0000_3000);
    tick();
    chk("t1_second_addr", s_addr, 32'h0000_3004);
    repeat (8) tick();
    chk("t1_pop0", popped_pc.size() > 1 ? popped_pc[0] : 32'hX, 32'h0000_3000);
    chk("t1_pop1", popped_pc.size() > 1 ? popped_pc[1] : 32'hX, 32'h0000_3004);

    // Decode stalls: issue stops once the buffer is committed, resumes after a pop.
    do_reset();
    if_ready = 1'b0;
    repeat (6) tick();
    chk("t2_stall_req", s_req, 1'b0);
    chk("t2_stall_valid", s_valid, 1'b1);
    chk("t2_head_pc", s_pc, 32'h0000_3000);
    if_ready = 1'b1;
    tick();
    tick();
    chk("t2_resume_req", s_req, 1'b1);
    chk("t2_resume_addr", s_addr, 32'h0000_3008);
    repeat (6) tick();

    // Grant withheld: request and address are held.
    do_reset();
    gnt_pct = 0;
    repeat (3) begin
      tick();
      chk("t3_held_req", s_req, 1'b1);
      chk("t3_held_addr", s_addr, 32'h0000_3000);
    end
    gnt_pct = 100;
    rv_pct  = 0;
    tick();
    tick();
    chk("t3_next_addr", s_addr, 32'h0000_3004);
    rv_pct = 100;
    repeat (6) tick();

    // Redirect with two requests in flight: both responses dropped.
    do_reset();
    rv_pct = 0;
    tick();
    tick();
    redirect = 1'b1;
    npc_in   = 32'h0000_3100;
    tick();
    chk("t4_redirect_req", s_req, 1'b0);
    redirect = 1'b0;
    rv_pct   = 100;
    popped_pc.delete();
    popped_instr.delete();
    repeat (8) tick();
    chk("t4_got_word", popped_pc.size() != 0, 1'b1);
    if (popped_pc.size() != 0) begin
      chk("t4_first_pc", popped_pc[0], 32'h0000_3100);
      chk("t4_first_instr", popped_instr[0], memfn(32'h0000_3100));
    end

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (2) tick();
    redirect = 1'b1;
    npc_in   = 32'h0000_3203;
    tick();
    chk("t5_rvalid_same_cycle", s_rv, 1'b1);
    chk("t5_pop_same_cycle", s_valid, 1'b1);
    redirect = 1'b0;
    tick();
    chk("t5_no_stale_valid", s_valid, 1'b0);
    chk("t5_req", s_req, 1'b1);
    chk("t5_addr", s_addr, 32'h0000_3200);
    repeat (6) tick();

    // Address wrap, then reset in the middle of the stream.
    do_reset();
    redirect = 1'b1;
    npc_in   = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("t6_top_addr", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_req", s_req, 1'b1);
    chk("t6_wrap_addr", s_addr, 32'h0000_0000);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_rst_valid", s_valid, 1'b0);
    chk("t6_rst_req", s_req, 1'b0);
    reset = 1'b0;
    tick();
    chk("t6_after_rst_addr", s_addr, 32'h0000_3000);
    chk("t6_after_rst_req", s_req, 1'b1);

    // Randomized traffic: stalls, back-to-back redirects, occasional reset.
    for (int n = 0; n < 4000; n++) begin
      gnt_pct  = $urandom_range(20, 100);
      rv_pct   = $urandom_range(20, 100);
      if_ready = ($urandom_range(3) != 0);
      redirect = ($urandom_range(99) < 6);
      npc_in   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom();
      reset    = ($urandom_range(299) == 0);
      tick();
    end
    reset    = 1'b0;
    redirect = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
